// File: rtl/regif_rd_client_pkg.sv
// rtl/regif_rd_client_pkg.sv - shared state encodings and width defaults for the regif read client
package regif_rd_client_pkg;

   typedef logic [7:0] state_t;

   // One-hot, 8-bit, same encoding style as the regif arbiters
   localparam state_t ST_IDLE     = 8'h01;
   localparam state_t ST_ISSUE    = 8'h02;
   localparam state_t ST_WAIT_ACK = 8'h04;
   localparam state_t ST_RSP      = 8'h08;

   localparam int DEF_ADDR_W = 23;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/regif_req_fifo.sv
// rtl/regif_req_fifo.sv - synchronous request FIFO with full/empty flags
module regif_req_fifo #(
   parameter int WIDTH = 23,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A simultaneous pop frees the slot, so a push while full is still accepted
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/regif_rd_client.sv
// rtl/regif_rd_client.sv - turn-token register read client: queues reads, bursts them per arbiter turn
module regif_rd_client
   import regif_rd_client_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_BURST  = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic              reg_int_clk,
   input  logic              reg_int_reset_n,
   input  logic              rdif_trn,
   output logic              rdif_drvn,
   input  logic              rd_req_valid,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_req_ready,
   output logic              reg_req,
   output logic              reg_rd_wr_L,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic              reg_ack,
   input  logic [DATA_W-1:0] reg_rd_data,
   output logic              rsp_valid,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              rsp_ready
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t            state;
   logic [TW-1:0]     tcnt;
   logic [TW-1:0]     tcnt_nxt;
   logic [BW-1:0]     burst;
   logic [BW-1:0]     burst_nxt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              fifo_push;
   logic [ADDR_W-1:0] fifo_head;

   // ISSUE is a registered state, so ready stays glitch-free while still allowing push-while-full
   assign fifo_pop     = (state == ST_ISSUE);
   assign rd_req_ready = !fifo_full || fifo_pop;
   assign fifo_push    = rd_req_valid && rd_req_ready;
   assign reg_rd_wr_L  = 1'b1;

   assign tcnt_nxt  = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
   assign burst_nxt = burst + 1'b1;

   regif_req_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (reg_int_clk),
      .rst_n     (reg_int_reset_n),
      .push      (fifo_push),
      .push_data (rd_req_addr),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge reg_int_clk or negedge reg_int_reset_n) begin
      if (!reg_int_reset_n) begin
         state     <= ST_IDLE;
         rdif_drvn <= 1'b0;
         reg_req   <= 1'b0;
         reg_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         tcnt      <= '0;
         burst     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // The arbiter samples drvn two cycles after trn, so this must answer at once
               if (rdif_trn && !fifo_empty) begin
                  rdif_drvn <= 1'b1;
                  burst     <= '0;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               reg_addr <= fifo_head;
               reg_req  <= 1'b1;
               tcnt     <= '0;
               state    <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (reg_ack) begin
                  reg_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_addr  <= reg_addr;
                  rsp_data  <= reg_rd_data;
                  rsp_err   <= 1'b0;
                  state     <= ST_RSP;
               end else if (tcnt_nxt == TW'(TIMEOUT)) begin
                  reg_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_addr  <= reg_addr;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= ST_RSP;
               end else begin
                  tcnt <= tcnt_nxt;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  burst     <= burst_nxt;
                  if ((burst_nxt < BW'(MAX_BURST)) && !fifo_empty) begin
                     state <= ST_ISSUE;
                  end else begin
                     rdif_drvn <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               rdif_drvn <= 1'b0;
               reg_req   <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regif_rd_client.sv
// tb/tb_regif_rd_client.sv - directed self-checking bench for regif_rd_client
module tb_regif_rd_client;

   logic        reg_int_clk = 1'b0;
   logic        reg_int_reset_n;
   logic        rdif_trn;
   logic        rdif_drvn;
   logic        rd_req_valid;
   logic [22:0] rd_req_addr;
   logic        rd_req_ready;
   logic        reg_req;
   logic        reg_rd_wr_L;
   logic [22:0] reg_addr;
   logic        reg_ack;
   logic [31:0] reg_rd_data;
   logic        rsp_valid;
   logic [22:0] rsp_addr;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;

   int tests = 0;
   int fails = 0;

   always #5 reg_int_clk = ~reg_int_clk;

   regif_rd_client #(
      .ADDR_W     (23),
      .DATA_W     (32),
      .FIFO_DEPTH (4),
      .MAX_BURST  (2),
      .TIMEOUT    (8)
   ) dut (
      .reg_int_clk     (reg_int_clk),
      .reg_int_reset_n (reg_int_reset_n),
      .rdif_trn        (rdif_trn),
      .rdif_drvn       (rdif_drvn),
      .rd_req_valid    (rd_req_valid),
      .rd_req_addr     (rd_req_addr),
      .rd_req_ready    (rd_req_ready),
      .reg_req         (reg_req),
      .reg_rd_wr_L     (reg_rd_wr_L),
      .reg_addr        (reg_addr),
      .reg_ack         (reg_ack),
      .reg_rd_data     (reg_rd_data),
      .rsp_valid       (rsp_valid),
      .rsp_addr        (rsp_addr),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .rsp_ready       (rsp_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge reg_int_clk);
      #1;
   endtask

   task automatic push(input logic [22:0] a);
      rd_req_valid = 1'b1;
      rd_req_addr  = a;
      tick;
      rd_req_valid = 1'b0;
   endtask

   task automatic pulse_trn;
      rdif_trn = 1'b1;
      tick;
      rdif_trn = 1'b0;
   endtask

   task automatic serve(input string tag, input logic [22:0] a, input logic [31:0] d);
      int n = 0;
      while (!reg_req && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_req"}, reg_req, 1);
      chk({tag, "_addr"}, reg_addr, a);
      reg_ack     = 1'b1;
      reg_rd_data = d;
      tick;
      reg_ack = 1'b0;
      chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_addr, rsp_data}, {1'b1, 1'b0, a, d});
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, rsp_valid, 0);
   endtask

   initial begin
      int  cnt;
      logic bad;

      reg_int_reset_n = 1'b0;
      rdif_trn = 1'b0; rd_req_valid = 1'b0; rd_req_addr = '0;
      reg_ack = 1'b0; reg_rd_data = '0; rsp_ready = 1'b0;
      tick; tick;
      chk("reset_ctrl", {rdif_drvn, reg_req, rsp_valid, rsp_err}, 4'b0000);
      chk("reset_data", {reg_addr, rsp_addr, rsp_data}, 0);
      reg_int_reset_n = 1'b1;
      tick;
      chk("reset_ready", rd_req_ready, 1);

      // 1: single read
      push(23'h10);
      pulse_trn;
      chk("t1_drvn", {rdif_drvn, reg_req}, 2'b10);
      tick;
      chk("t1_bus", {reg_req, reg_rd_wr_L, reg_addr}, {1'b1, 1'b1, 23'h10});
      reg_ack = 1'b1; reg_rd_data = 32'hDEADBEEF;
      tick;
      reg_ack = 1'b0;
      chk("t1_rsp", {reg_req, rsp_valid, rsp_err, rsp_addr, rsp_data},
          {1'b0, 1'b1, 1'b0, 23'h10, 32'hDEADBEEF});
      chk("t1_drvn_held", rdif_drvn, 1);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("t1_drvn_drop", {rdif_drvn, rsp_valid}, 2'b00);

      // 2: turn with empty queue
      pulse_trn;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rdif_drvn || reg_req) bad = 1'b1;
         tick;
      end
      chk("t2_empty_trn", bad, 0);

      // 3: burst limit
      push(23'h1); push(23'h2); push(23'h3);
      pulse_trn;
      chk("t3_drvn", rdif_drvn, 1);
      serve("t3_a", 23'h1, 32'h0000_0111);
      chk("t3_drvn_mid", rdif_drvn, 1);
      serve("t3_b", 23'h2, 32'h0000_0222);
      chk("t3_drvn_end", rdif_drvn, 0);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (reg_req || rdif_drvn) bad = 1'b1;
         tick;
      end
      chk("t3_third_waits", bad, 0);
      pulse_trn;
      serve("t3_c", 23'h3, 32'h0000_0333);
      chk("t3_drvn_final", rdif_drvn, 0);

      // 4: timeout, then ack on the last allowed cycle
      push(23'h40);
      pulse_trn;
      tick;
      cnt = 0;
      while (reg_req && cnt < 20) begin
         tick;
         cnt++;
      end
      chk("t4_timeout_len", cnt, 8);
      chk("t4_rsp", {rsp_valid, rsp_err, rsp_addr, rsp_data}, {1'b1, 1'b1, 23'h40, 32'h0});
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      chk("t4_drvn", rdif_drvn, 0);
      push(23'h41);
      pulse_trn;
      tick;
      for (int i = 0; i < 7; i++) tick;
      chk("t4_still_req", reg_req, 1);
      reg_ack = 1'b1; reg_rd_data = 32'h12345678;
      tick;
      reg_ack = 1'b0;
      chk("t4_ack_wins", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 32'h12345678});
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;

      // 5: backpressure, fill queue, push+pop while full
      push(23'h50);
      pulse_trn;
      tick;
      reg_ack = 1'b1; reg_rd_data = 32'hCAFE0001;
      tick;
      reg_ack = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 23'h51 + 23'(i);
         end else begin
            rd_req_valid = 1'b0;
         end
         if (!rsp_valid || rsp_addr !== 23'h50 || rsp_data !== 32'hCAFE0001 || !rdif_drvn) bad = 1'b1;
         tick;
      end
      rd_req_valid = 1'b0;
      chk("t5_rsp_stable", bad, 0);
      chk("t5_full", rd_req_ready, 0);
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      rd_req_valid = 1'b1; rd_req_addr = 23'h55;
      chk("t5_ready_on_pop", rd_req_ready, 1);
      tick;
      rd_req_valid = 1'b0;
      chk("t5_still_full", {rd_req_ready, reg_req, reg_addr}, {1'b0, 1'b1, 23'h51});
      serve("t5_a", 23'h51, 32'hA1);
      chk("t5_drvn_a", rdif_drvn, 0);
      pulse_trn;
      serve("t5_b", 23'h52, 32'hA2);
      serve("t5_c", 23'h53, 32'hA3);
      pulse_trn;
      serve("t5_d", 23'h54, 32'hA4);
      serve("t5_e", 23'h55, 32'hA5);
      chk("t5_end", {rdif_drvn, rd_req_ready}, 2'b01);

      // 6: reset during WAIT_ACK
      push(23'h60); push(23'h61);
      pulse_trn;
      tick;
      chk("t6_in_wait", reg_req, 1);
      #2;
      reg_int_reset_n = 1'b0;
      #1;
      chk("t6_async_reset", {rdif_drvn, reg_req, rsp_valid, rsp_err, reg_addr, rsp_addr, rsp_data}, 0);
      tick;
      reg_int_reset_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         reg_ack = (i % 3 == 0);
         if (rsp_valid || reg_req || rdif_drvn) bad = 1'b1;
         tick;
      end
      reg_ack = 1'b0;
      chk("t6_no_rsp", bad, 0);
      pulse_trn;
      tick;
      chk("t6_queue_empty", {rdif_drvn, reg_req}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
